// File: rtl/enc_pkg.sv
// Shared types and sizing for the 4-to-2 handshake encoder.
// Holds the controller state enum and the input/code widths.
package enc_pkg;

  localparam int N_IN   = 4;
  localparam int CODE_W = 2;

  typedef enum logic {
    IDLE,
    PRESENT
  } state_t;

endpackage

// File: rtl/encoder4x2_hs_pick.sv
// Combinational picker: first set bit of vec searching downward
// from start with wrap-around; found is low when vec is empty.
module enc_pick
  import enc_pkg::*;
(
  input  logic [N_IN-1:0]   vec,
  input  logic [CODE_W-1:0] start,
  output logic [CODE_W-1:0] idx,
  output logic              found
);

  logic [CODE_W-1:0] k;

  // Lowest-priority position first so the start position wins last.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    k     = '0;
    for (int i = N_IN - 1; i >= 0; i--) begin
      k = start - CODE_W'(i);
      if (vec[k]) begin
        idx   = k;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/encoder4x2_hs.sv
// 4-to-2 encoder with valid/ready on both sides; drains a latched batch.
// Define ENCODER_RR_EN for round-robin picking instead of D3>D0 priority.
module encoder4x2_hs
  import enc_pkg::*;
#(
  parameter logic [CODE_W-1:0] CODE_RST = 2'b00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_IN-1:0]   d,
  input  logic              d_valid,
  output logic              d_ready,
  output logic [CODE_W-1:0] code,
  output logic              code_valid,
  input  logic              code_ready,
  output logic              multi,
  output logic              zero_err
);

  state_t              state, state_nx;
  logic [N_IN-1:0]     pend, pend_nx;
  logic [N_IN-1:0]     rem, pick_vec;
  logic [CODE_W-1:0]   code_nx, pick_start, pick_idx;
  logic                pick_found;
  logic                cv_nx, multi_nx, zero_nx;
  logic                accept, pop;

  assign d_ready  = (state == IDLE);
  assign accept   = d_valid && d_ready;
  assign pop      = code_valid && code_ready;
  assign rem      = pend & ~(N_IN'(1) << code);
  assign pick_vec = (state == IDLE) ? d : rem;

`ifdef ENCODER_RR_EN
  logic [CODE_W-1:0] last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   last <= '0;
    else if (pop) last <= code;
  end

  // On a pop the code being popped becomes the new "last".
  assign pick_start = (state == IDLE) ? (last - CODE_W'(1))
                                      : (code - CODE_W'(1));
`else
  assign pick_start = CODE_W'(N_IN - 1);
`endif

  enc_pick u_pick (
    .vec   (pick_vec),
    .start (pick_start),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    state_nx = state;
    pend_nx  = pend;
    code_nx  = code;
    cv_nx    = code_valid;
    multi_nx = multi;
    zero_nx  = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (d != '0) begin
            pend_nx  = d;
            code_nx  = pick_idx;
            cv_nx    = 1'b1;
            multi_nx = ($countones(d) > 1);
            state_nx = PRESENT;
          end else begin
            zero_nx  = 1'b1;
          end
        end
      end
      PRESENT: begin
        if (pop) begin
          if (pick_found) begin
            pend_nx  = rem;
            code_nx  = pick_idx;
          end else begin
            pend_nx  = '0;
            code_nx  = CODE_RST;
            cv_nx    = 1'b0;
            multi_nx = 1'b0;
            state_nx = IDLE;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pend       <= '0;
      code       <= CODE_RST;
      code_valid <= 1'b0;
      multi      <= 1'b0;
      zero_err   <= 1'b0;
    end else begin
      state      <= state_nx;
      pend       <= pend_nx;
      code       <= code_nx;
      code_valid <= cv_nx;
      multi      <= multi_nx;
      zero_err   <= zero_nx;
    end
  end

endmodule

// File: tb/tb_encoder4x2_hs.sv
// Self-checking bench for encoder4x2_hs: directed cases plus random
// traffic against a queue-based batch model.
module tb_encoder4x2_hs;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] d = '0;
  logic       d_valid = 1'b0;
  logic       d_ready;
  logic [1:0] code;
  logic       code_valid;
  logic       code_ready = 1'b0;
  logic       multi;
  logic       zero_err;

  localparam logic [1:0] RST_CODE = 2'b00;

  always #5 clk = ~clk;

  encoder4x2_hs #(.CODE_RST(RST_CODE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .d          (d),
    .d_valid    (d_valid),
    .d_ready    (d_ready),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .multi      (multi),
    .zero_err   (zero_err)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Model: the codes still owed by the current batch, in output order.
  int q[$];
  int last_m  = 0;
  bit zero_m  = 1'b0;
  bit multi_m = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick_m(input int v, input int start);
    for (int o = 0; o < 4; o++) begin
      int k;
      k = (start - o + 4) % 4;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    q.delete();
    last_m  = 0;
    zero_m  = 1'b0;
    multi_m = 1'b0;
  endtask

  task automatic model_step(input bit [3:0] din, input bit dv,
                            input bit cr);
    zero_m = 1'b0;
    if (q.size() == 0) begin
      if (dv) begin
        if (din == 4'b0000) begin
          zero_m = 1'b1;
        end else begin
          int rem;
          int l;
          rem = int'(din);
          l   = last_m;
          while (rem != 0) begin
            int s;
            int k;
`ifdef ENCODER_RR_EN
            s = (l + 3) % 4;
`else
            s = 3;
`endif
            k = pick_m(rem, s);
            q.push_back(k);
            rem = rem & ~(1 << k);
            l = k;
          end
          multi_m = ($countones(din) > 1);
        end
      end
    end else if (cr) begin
      last_m = q.pop_front();
      if (q.size() == 0) multi_m = 1'b0;
    end
  endtask

  task automatic check_outputs(input string tag);
    int ec;
    ec = (q.size() != 0) ? q[0] : int'(RST_CODE);
    check({tag, ".code"},  32'(code),       32'(ec));
    check({tag, ".cv"},    32'(code_valid), 32'(q.size() != 0));
    check({tag, ".multi"}, 32'(multi),      32'(multi_m));
    check({tag, ".zero"},  32'(zero_err),   32'(zero_m));
    check({tag, ".rdy"},   32'(d_ready),    32'(q.size() == 0));
  endtask

  task automatic cycle(input bit [3:0] din, input bit dv, input bit cr,
                       input string tag);
    d          = din;
    d_valid    = dv;
    code_ready = cr;
    model_step(din, dv, cr);
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    model_reset();
    #2;
    check_outputs("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check(  "rel.rdy", 32'(d_ready), 32'd1);
    cycle(4'b0000, 1'b0, 1'b0, "post_rst");

    // Single request
    cycle(4'b0100, 1'b1, 1'b0, "acc0100");
    check("acc0100.c2", 32'(code), 32'd2);
    check("acc0100.m0", 32'(multi), 32'd0);
    cycle(4'b0000, 1'b0, 1'b1, "pop0100");
    check("pop0100.cv", 32'(code_valid), 32'd0);

    // Multi-hot batch drained back-to-back
    cycle(4'b1011, 1'b1, 1'b1, "acc1011");
`ifndef ENCODER_RR_EN
    check("b1011.c3", 32'(code), 32'd3);
`endif
    check("b1011.m1", 32'(multi), 32'd1);
    cycle(4'b0000, 1'b0, 1'b1, "b1011.p1");
`ifndef ENCODER_RR_EN
    check("b1011.c1", 32'(code), 32'd1);
`endif
    cycle(4'b0000, 1'b0, 1'b1, "b1011.p2");
`ifndef ENCODER_RR_EN
    check("b1011.c0", 32'(code), 32'd0);
`endif
    check("b1011.m1b", 32'(multi), 32'd1);
    cycle(4'b0000, 1'b0, 1'b1, "b1011.p3");
    check("b1011.idle", 32'(d_ready), 32'd1);

    // All-zero request
    cycle(4'b0000, 1'b1, 1'b0, "zero");
    check("zero.pulse", 32'(zero_err), 32'd1);
    cycle(4'b0000, 1'b0, 1'b0, "zero.end");
    check("zero.clr", 32'(zero_err), 32'd0);

    // Backpressure with ignored input traffic
    cycle(4'b0110, 1'b1, 1'b0, "bp.acc");
    for (int i = 0; i < 5; i++) begin
      cycle(4'b0001, 1'b1, 1'b0, "bp.hold");
`ifndef ENCODER_RR_EN
      check("bp.c2", 32'(code), 32'd2);
`endif
    end
    cycle(4'b0000, 1'b0, 1'b1, "bp.p1");
    cycle(4'b0000, 1'b0, 1'b1, "bp.p2");
    check("bp.done", 32'(code_valid), 32'd0);

    // Asynchronous reset mid-batch
    cycle(4'b1110, 1'b1, 1'b0, "mr.acc");
    cycle(4'b0000, 1'b0, 1'b1, "mr.p1");
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("mr.async");
    cycle(4'b0000, 1'b0, 1'b1, "mr.inrst");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(4'b0000, 1'b0, 1'b1, "mr.after");
      check("mr.nocode", 32'(code_valid), 32'd0);
    end

`ifdef ENCODER_RR_EN
    // Pointer follows the last popped code
    cycle(4'b1001, 1'b1, 1'b0, "rr.a");
    check("rr.a3", 32'(code), 32'd3);
    cycle(4'b0000, 1'b0, 1'b1, "rr.ap1");
    check("rr.a0", 32'(code), 32'd0);
    cycle(4'b0000, 1'b0, 1'b1, "rr.ap2");
    cycle(4'b1100, 1'b1, 1'b0, "rr.b");
    check("rr.b3", 32'(code), 32'd3);
    cycle(4'b0000, 1'b0, 1'b1, "rr.bp1");
    check("rr.b2", 32'(code), 32'd2);
    cycle(4'b0000, 1'b0, 1'b1, "rr.bp2");
`endif

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
